// File: rtl/ef_apb_pkg.sv
// Shared definitions for the APB initiator and its companion slave BFM:
// FSM state encoding and the PSEL/PENABLE pattern that belongs to each phase.
package ef_apb_pkg;

    // Transfer FSM: one APB transfer in flight at a time.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Bus-control pattern of one APB phase.
    typedef struct packed {
        logic psel;
        logic penable;
    } apb_phase_t;

    localparam apb_phase_t PHASE_IDLE   = '{psel: 1'b0, penable: 1'b0};
    localparam apb_phase_t PHASE_SETUP  = '{psel: 1'b1, penable: 1'b0};
    localparam apb_phase_t PHASE_ACCESS = '{psel: 1'b1, penable: 1'b1};

    // Bus-control pattern driven while the FSM sits in a given state.
    // RESP is not an APB phase: the bus is released while the local agent
    // collects the response.
    function automatic apb_phase_t phase_of(apb_state_e st);
        apb_phase_t ph;
        case (st)
            ST_SETUP:  ph = PHASE_SETUP;
            ST_ACCESS: ph = PHASE_ACCESS;
            default:   ph = PHASE_IDLE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/ef_apb_master.sv
// APB initiator: turns one valid/ready request into one APB transfer
// (SETUP, then ACCESS with PREADY wait states and an optional timeout) and
// returns read data or a timeout flag on a valid/ready response channel.
// Every output is a flop; next values are computed from the next state so
// that bus controls line up with the state they belong to.
module ef_apb_master
    import ef_apb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          PCLK,
    input  logic          PRESET,
    // request channel
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    // response channel
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_timeout,
    // APB
    output logic          PSEL,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [AW-1:0] PADDR,
    output logic [DW-1:0] PWDATA,
    input  logic [DW-1:0] PRDATA,
    input  logic          PREADY
);

    // Wait counter only needs to reach TIMEOUT-1; keep at least one bit so
    // the TIMEOUT=0 (wait forever) build still has a legal vector.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);

    apb_state_e    state_q, state_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    logic          pwrite_q, pwrite_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    apb_phase_t    phase_d;

    // Transfers are word accesses: the byte-lane bits of the request address
    // are discarded on capture.
    logic addr_lsb_unused;
    assign addr_lsb_unused = ^req_addr[1:0];

    // Next-state, capture registers, wait counter and registered outputs.
    always_comb begin
        state_d       = state_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_rdata_d   = rsp_rdata_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        cnt_d         = cnt_q;

        case (state_q)
            ST_IDLE: begin
                // req_ready_q guards the first cycle after reset, when the
                // FSM is already IDLE but the request port is still closed.
                if (req_valid && req_ready_q) begin
                    pwrite_d = req_write;
                    paddr_d  = {req_addr[AW-1:2], 2'b00};
                    pwdata_d = req_wdata;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY is checked first so a slave answering on the last
                // permitted cycle still completes normally.
                if (PREADY) begin
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        phase_d     = phase_of(state_d);
        psel_d      = phase_d.psel;
        penable_d   = phase_d.penable;
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            cnt_q         <= cnt_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_ef_apb_master.sv
// Directed bench for ef_apb_master with a behavioural APB slave: a word
// memory plus, in UART mode, a loopback byte FIFO at 0x0 with a
// "data available" status bit (bit 5) at 0x204.
`timescale 1ns/1ps
module tb_ef_apb_master;

    logic        PCLK;
    logic        PRESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    ef_apb_master #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // ---------------- behavioural slave ----------------
    int          wait_states = 0;   // PREADY after this many stalled ACCESS cycles
    bit          stall_all   = 0;   // ignore wait_states, use ready_at
    int          ready_at    = 0;   // 0 = never ready, else ready on that ACCESS cycle
    bit          uart_mode   = 0;
    int          acc_cnt     = 0;
    logic [31:0] mem [0:255];
    logic [7:0]  fifo [0:15];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    assign PREADY = PSEL && PENABLE &&
                    (stall_all ? (ready_at != 0 && acc_cnt == ready_at - 1)
                               : (acc_cnt >= wait_states));

    always_comb begin
        PRDATA = 32'h0;
        if (uart_mode && PADDR == 32'h0)
            PRDATA = (rd_ptr != wr_ptr) ? {24'h0, fifo[rd_ptr[3:0]]} : 32'h0;
        else if (uart_mode && PADDR == 32'h204)
            PRDATA = {26'h0, (rd_ptr != wr_ptr), 5'h0};
        else
            PRDATA = mem[PADDR[9:2]];
    end

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (PSEL && PENABLE && PREADY) begin
            if (PWRITE) begin
                if (uart_mode && PADDR == 32'h0) begin
                    fifo[wr_ptr[3:0]] <= PWDATA[7:0];
                    wr_ptr <= wr_ptr + 1;
                end else begin
                    mem[PADDR[9:2]] <= PWDATA;
                end
            end else if (uart_mode && PADDR == 32'h0 && rd_ptr != wr_ptr) begin
                rd_ptr <= rd_ptr + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Per-transfer observations, sampled 1 ns after each rising edge.
    logic        psel1, pen1, pen2, psel_in_resp;
    logic [31:0] first_paddr;
    int          acc_seen, paddr_moved, hold_bad;

    // One request/response. lat counts edges from acceptance (edge N) to the
    // edge at which rsp_valid is first seen high. hold = cycles to keep
    // rsp_ready low (with req_valid high) once the response is up.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd, output logic tmo, output int lat);
        int n;
        int k;
        rd = 32'hDEAD_BEEF; tmo = 1'bx; lat = -1;
        acc_seen = 0; paddr_moved = 0; hold_bad = 0;
        req_write = wr; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge PCLK); #1; n++;
        end
        if (!req_ready) begin
            check_eq("req_ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge PCLK); #1;
        req_valid = 1'b0;
        k = 1;
        first_paddr = PADDR; psel1 = PSEL; pen1 = PENABLE; pen2 = 1'b0;
        while (!rsp_valid && k < 100) begin
            if (PSEL && PENABLE) acc_seen++;
            if (PSEL && PADDR != first_paddr) paddr_moved++;
            @(posedge PCLK); #1; k++;
            if (k == 2) pen2 = PENABLE;
        end
        lat = k;
        if (!rsp_valid) begin
            check_eq("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
            return;
        end
        psel_in_resp = PSEL;
        rd  = rsp_rdata;
        tmo = rsp_timeout;
        req_valid = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            if (!rsp_valid || rsp_rdata != rd || req_ready || PSEL) hold_bad++;
            @(posedge PCLK); #1;
        end
        rsp_ready = 1'b1; req_valid = 1'b0;
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;
    logic        tmo;
    int          lat;
    int          n;

    initial begin
        PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        check_eq("rst_req_ready",   32'(req_ready),   32'd0);
        check_eq("rst_rsp_valid",   32'(rsp_valid),   32'd0);
        check_eq("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check_eq("rst_psel",        32'(PSEL),        32'd0);
        check_eq("rst_penable",     32'(PENABLE),     32'd0);
        check_eq("rst_pwrite",      32'(PWRITE),      32'd0);
        check_eq("rst_paddr",       PADDR,            32'h0);
        check_eq("rst_pwdata",      PWDATA,           32'h0);
        check_eq("rst_rsp_rdata",   rsp_rdata,        32'h0);
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        check_eq("req_ready_after_rst", 32'(req_ready), 32'd1);

        // 1: zero-wait write
        xfer(1'b1, 32'h4, 32'h2, 0, rd, tmo, lat);
        check_eq("t1_psel_n1",   32'(psel1), 32'd1);
        check_eq("t1_pen_n1",    32'(pen1),  32'd0);
        check_eq("t1_pen_n2",    32'(pen2),  32'd1);
        check_eq("t1_latency",   32'(lat),   32'd3);
        check_eq("t1_timeout",   32'(tmo),   32'd0);
        check_eq("t1_rdata",     rd,         32'h0);
        check_eq("t1_slave_mem", mem[1],     32'h2);

        // 2: read with three wait states
        xfer(1'b1, 32'h204, 32'hA5, 0, rd, tmo, lat);
        wait_states = 3;
        xfer(1'b0, 32'h204, 32'h0, 0, rd, tmo, lat);
        check_eq("t2_latency",     32'(lat),         32'd6);
        check_eq("t2_rdata",       rd,               32'hA5);
        check_eq("t2_timeout",     32'(tmo),         32'd0);
        check_eq("t2_access_cyc",  32'(acc_seen),    32'd4);
        check_eq("t2_paddr",       first_paddr,      32'h204);
        check_eq("t2_paddr_moved", 32'(paddr_moved), 32'd0);
        wait_states = 0;

        // 3: timeout after exactly 8 ACCESS cycles, then PREADY on the 8th
        stall_all = 1; ready_at = 0;
        xfer(1'b0, 32'h204, 32'h0, 0, rd, tmo, lat);
        check_eq("t3_access_cyc", 32'(acc_seen),     32'd8);
        check_eq("t3_timeout",    32'(tmo),          32'd1);
        check_eq("t3_rdata",      rd,                32'h0);
        check_eq("t3_psel_resp",  32'(psel_in_resp), 32'd0);
        ready_at = 8;
        xfer(1'b0, 32'h204, 32'h0, 0, rd, tmo, lat);
        check_eq("t3b_access_cyc", 32'(acc_seen), 32'd8);
        check_eq("t3b_timeout",    32'(tmo),      32'd0);
        check_eq("t3b_rdata",      rd,            32'hA5);
        stall_all = 0; ready_at = 0;

        // 4: response back-pressure for 10 cycles
        xfer(1'b0, 32'h204, 32'h0, 10, rd, tmo, lat);
        check_eq("t4_rdata",        rd,                32'hA5);
        check_eq("t4_hold_viol",    32'(hold_bad),     32'd0);
        check_eq("t4_valid_after",  32'(rsp_valid),    32'd0);
        check_eq("t4_ready_after",  32'(req_ready),    32'd1);

        // 5: reset during ACCESS, then a normal write
        stall_all = 1; ready_at = 0;
        req_write = 1'b0; req_addr = 32'h204; req_valid = 1'b1;
        @(posedge PCLK); #1;
        req_valid = 1'b0;
        @(posedge PCLK); #1;
        check_eq("t5_in_access", 32'(PENABLE), 32'd1);
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        check_eq("t5_psel_rst", 32'(PSEL),    32'd0);
        check_eq("t5_pen_rst",  32'(PENABLE), 32'd0);
        PRESET = 1'b0;
        n = 0;
        repeat (12) begin
            if (rsp_valid || PSEL) n++;
            @(posedge PCLK); #1;
        end
        check_eq("t5_no_rsp", 32'(n), 32'd0);
        stall_all = 0;
        xfer(1'b1, 32'h100, 32'h7, 0, rd, tmo, lat);
        check_eq("t5_latency", 32'(lat), 32'd3);
        check_eq("t5_timeout", 32'(tmo), 32'd0);
        check_eq("t5_mem",     mem[8'h40], 32'h7);
        xfer(1'b1, 32'h10B, 32'h3C, 0, rd, tmo, lat);
        check_eq("t5_paddr_lsb", first_paddr, 32'h108);
        check_eq("t5_mem_lsb",   mem[8'h42],  32'h3C);

        // 6: UART loopback
        uart_mode = 1; wait_states = 1;
        xfer(1'b1, 32'h4,   32'h2, 0, rd, tmo, lat);
        xfer(1'b1, 32'hC,   32'h7, 0, rd, tmo, lat);
        xfer(1'b1, 32'h100, 32'h7, 0, rd, tmo, lat);
        for (int i = 0; i < 8; i++)
            xfer(1'b1, 32'h0, 32'(8'h11 * (i + 1)), 0, rd, tmo, lat);
        n = 0;
        rd = 32'h0;
        while (!rd[5] && n < 20) begin
            xfer(1'b0, 32'h204, 32'h0, 0, rd, tmo, lat);
            n++;
        end
        check_eq("t6_rx_avail", 32'(rd[5]), 32'd1);
        for (int i = 0; i < 8; i++) begin
            xfer(1'b0, 32'h0, 32'h0, 0, rd, tmo, lat);
            check_eq($sformatf("t6_rx_byte%0d", i), rd, 32'(8'h11 * (i + 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
